cpu_mem_bridge: RTL and testbench

//  Bridges the CPU's instruction-fetch and data-memory ports onto one shared external memory

---
 rtl/cpu_mem_bridge_if.sv | 22 ++
 rtl/cpu_mem_bridge.sv | 127 ++++++++++++
 tb/tb_cpu_mem_bridge.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_bridge_if.sv
// cpu_mem_bridge_if: shared memory request/ack bus between the bridge (master) and the memory controller (slave)
// Signals: mem_req/mem_we/mem_addr/mem_wdata/mem_wmask driven by the master; mem_ack/mem_rdata driven by the slave.
interface cpu_mem_bridge_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wmask;
  logic                mem_ack;
  logic [DATA_W-1:0]   mem_rdata;
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_ack, mem_rdata
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: serialises CPU instruction fetches, loads and stores onto one request/ack memory bus
// Ports: clk_from_ip, rst (synchronous, active high); ic_addr/ic_data_out instruction port backed by a
// one-word buffer; dmem_read_in/dmem_write_in/dmem_addr/data_from_reg/dc_byte_w_en/dmem_data_out data port;
// mem_stall (combinational) freezes the CPU; bus (cpu_mem_bridge_if.master) is the memory side.
// Define CPU_IF_WRITE_BUFFER_EN to add a one-entry posted write buffer.
module cpu_mem_bridge #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
) (
  input  logic                clk_from_ip,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   ic_addr,
  output logic [DATA_W-1:0]   ic_data_out,
  input  logic                dmem_read_in,
  input  logic                dmem_write_in,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W-1:0]   data_from_reg,
  input  logic [DATA_W/8-1:0] dc_byte_w_en,
  output logic [DATA_W-1:0]   dmem_data_out,
  output logic                mem_stall,
  cpu_mem_bridge_if.master    bus
);
  typedef enum logic [1:0] {IDLE, DREAD, DWRITE, IFETCH} state_t;
  state_t state, state_n;
  logic ibuf_valid;
  logic [ADDR_W-1:0] ibuf_tag, l_addr;
  logic [DATA_W-1:0] load_q, l_wdata;
  logic [DATA_W/8-1:0] l_wmask;
  logic dop, rd_op, wr_op, ic_miss, rd_ack, wr_ack, i_ack, d_stall, load_upd;
  // read and write together is treated as no data operation
  assign dop = dmem_read_in ^ dmem_write_in;
  assign rd_op = dop && dmem_read_in;
  assign wr_op = dop && dmem_write_in;
  assign ic_miss = !ibuf_valid || ibuf_tag != ic_addr;
  assign rd_ack = bus.mem_ack && state == DREAD;
  assign wr_ack = bus.mem_ack && state == DWRITE;
  assign i_ack = bus.mem_ack && state == IFETCH;
  // nothing is pending while reset is held, so the CPU is not frozen during reset
  assign mem_stall = !rst && (d_stall || (ic_miss && !i_ack));
`ifdef CPU_IF_WRITE_BUFFER_EN
  logic wb_valid, wb_hit, wr_acc;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data, merged;
  logic [DATA_W/8-1:0] wb_mask;
  assign wb_hit = rd_op && wb_valid && wb_addr == dmem_addr;
  // a store lands in an empty buffer, or in the slot freed by the drain ack
  assign wr_acc = wr_op && (!wb_valid || wr_ack);
  assign d_stall = wr_op ? !wr_acc : rd_op && !(wb_hit || rd_ack);
  assign load_upd = rd_ack || wb_hit;
  assign l_addr = state_n == IFETCH ? ic_addr : state_n == DWRITE ? wb_addr : dmem_addr;
  assign l_wdata = wb_data;
  assign l_wmask = wb_mask;
  // bytes not covered by the buffered store come from the last load
  always_comb begin
    merged = load_q;
    for (int i = 0; i < DATA_W/8; i++)
      if (wb_mask[i]) merged[8*i +: 8] = wb_data[8*i +: 8];
  end
  assign dmem_data_out = rd_ack ? bus.mem_rdata : wb_hit ? merged : load_q;
  // draining the buffer comes before any new read or fetch
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = wb_valid ? DWRITE : rd_op ? DREAD : ic_miss ? IFETCH : IDLE;
    else if (bus.mem_ack) state_n = IDLE;
  end
  always_ff @(posedge clk_from_ip)
    if (rst) begin
      wb_valid <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      wb_mask <= '0;
    end else if (wr_acc) begin
      wb_valid <= 1'b1;
      wb_addr <= dmem_addr;
      wb_data <= data_from_reg;
      wb_mask <= dc_byte_w_en;
    end else if (wr_ack) begin
      wb_valid <= 1'b0;
    end
`else
  assign d_stall = dop && !(rd_ack || wr_ack);
  assign load_upd = rd_ack;
  assign l_addr = state_n == IFETCH ? ic_addr : dmem_addr;
  assign l_wdata = data_from_reg;
  assign l_wmask = dc_byte_w_en;
  // load data bypasses the register in the ack cycle so it is valid as mem_stall falls
  assign dmem_data_out = rd_ack ? bus.mem_rdata : load_q;
  // data accesses win over fetches
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = wr_op ? DWRITE : rd_op ? DREAD : ic_miss ? IFETCH : IDLE;
    else if (bus.mem_ack) state_n = IDLE;
  end
`endif
  always_ff @(posedge clk_from_ip)
    if (rst) begin
      state <= IDLE;
      bus.mem_req <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wmask <= '0;
      ibuf_valid <= 1'b0;
      ibuf_tag <= '0;
      ic_data_out <= '0;
      load_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n != IDLE) begin
        bus.mem_req <= 1'b1;
        bus.mem_we <= state_n == DWRITE;
        bus.mem_addr <= l_addr;
        bus.mem_wdata <= l_wdata;
        bus.mem_wmask <= l_wmask;
      end else if (state != IDLE && bus.mem_ack) begin
        bus.mem_req <= 1'b0;
      end
      if (i_ack) begin
        ibuf_tag <= ic_addr;
        ibuf_valid <= 1'b1;
        ic_data_out <= bus.mem_rdata;
      end
      // a store over the buffered instruction word makes it stale
      if (wr_ack && bus.mem_addr == ibuf_tag) ibuf_valid <= 1'b0;
      if (load_upd) load_q <= dmem_data_out;
    end
endmodule

// File: tb/tb_cpu_mem_bridge.sv
// tb_cpu_mem_bridge: directed self-checking bench for cpu_mem_bridge with a latency-programmable memory model
module tb_cpu_mem_bridge;
  logic clk_from_ip = 1'b0;
  logic rst = 1'b1;
  logic [29:0] ic_addr = '0;
  logic [29:0] dmem_addr = '0;
  logic [31:0] data_from_reg = '0;
  logic [3:0] dc_byte_w_en = '0;
  logic dmem_read_in = 1'b0;
  logic dmem_write_in = 1'b0;
  logic [31:0] ic_data_out, dmem_data_out;
  logic mem_stall;
  int checks = 0;
  int failures = 0;
  int lat = 1;
  logic [31:0] mem_arr [logic [29:0]];
  logic [29:0] log_addr [$];
  logic log_we [$];
  always #5 clk_from_ip = ~clk_from_ip;
  cpu_mem_bridge_if #(.ADDR_W(30), .DATA_W(32)) bus ();
  cpu_mem_bridge #(.ADDR_W(30), .DATA_W(32)) dut (
    .clk_from_ip(clk_from_ip),
    .rst(rst),
    .ic_addr(ic_addr),
    .ic_data_out(ic_data_out),
    .dmem_read_in(dmem_read_in),
    .dmem_write_in(dmem_write_in),
    .dmem_addr(dmem_addr),
    .data_from_reg(data_from_reg),
    .dc_byte_w_en(dc_byte_w_en),
    .dmem_data_out(dmem_data_out),
    .mem_stall(mem_stall),
    .bus(bus)
  );
  // memory model: acks lat+1 falling edges after a request is first seen, one-cycle ack pulse
  initial begin
    int cnt;
    logic [31:0] w;
    cnt = 0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk_from_ip);
      if (rst) begin
        bus.mem_ack = 1'b0;
        cnt = 0;
      end else if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req) begin
        if (cnt >= lat) begin
          cnt = 0;
          bus.mem_ack = 1'b1;
          w = mem_arr.exists(bus.mem_addr) ? mem_arr[bus.mem_addr] : 32'h0;
          if (bus.mem_we) begin
            for (int b = 0; b < 4; b++) if (bus.mem_wmask[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
            mem_arr[bus.mem_addr] = w;
          end else begin
            bus.mem_rdata = w;
          end
          log_addr.push_back(bus.mem_addr);
          log_we.push_back(bus.mem_we);
        end else begin
          cnt++;
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
  // drives one data op, counts stalled cycles, captures the first bus request and the data in the cycle stall falls
  task automatic do_op(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] d, input logic [3:0] be,
                       output int st, output logic [31:0] q, output logic [29:0] fa, output logic fwe,
                       output logic [31:0] fwd, output logic [3:0] fm);
    logic seen;
    @(negedge clk_from_ip);
    dmem_read_in = rd;
    dmem_write_in = wr;
    dmem_addr = a;
    data_from_reg = d;
    dc_byte_w_en = be;
    st = 0;
    seen = 1'b0;
    fa = '0;
    fwe = 1'b0;
    fwd = '0;
    fm = '0;
    #1;
    while (mem_stall && st < 100) begin
      if (bus.mem_req && !seen) begin
        seen = 1'b1;
        fa = bus.mem_addr;
        fwe = bus.mem_we;
        fwd = bus.mem_wdata;
        fm = bus.mem_wmask;
      end
      st++;
      @(negedge clk_from_ip);
      #1;
    end
    q = dmem_data_out;
    @(negedge clk_from_ip);
    dmem_read_in = 1'b0;
    dmem_write_in = 1'b0;
  endtask
  task automatic test_reset;
    @(negedge clk_from_ip);
    @(negedge clk_from_ip);
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", bus.mem_req); end
    checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL reset_mem_stall got=%b exp=0", mem_stall); end
    checks++; if (bus.mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", bus.mem_we); end
    checks++; if (dmem_data_out !== 32'h0) begin failures++; $display("FAIL reset_dmem_data_out got=%h exp=0", dmem_data_out); end
    checks++; if (ic_data_out !== 32'h0) begin failures++; $display("FAIL reset_ic_data_out got=%h exp=0", ic_data_out); end
    @(negedge clk_from_ip);
    rst = 1'b0;
  endtask
  task automatic test_fetch;
    int n;
    lat = 2;
    n = 0;
    #1;
    checks++; if (mem_stall !== 1'b1) begin failures++; $display("FAIL fetch_miss_stall got=%b exp=1", mem_stall); end
    while (mem_stall && n < 50) begin
      n++;
      @(negedge clk_from_ip);
      #1;
    end
    checks++; if (n !== 3) begin failures++; $display("FAIL fetch_stall_cycles got=%0d exp=3", n); end
    @(negedge clk_from_ip);
    #1;
    checks++; if (ic_data_out !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_ic_data got=%h exp=deadbeef", ic_data_out); end
    checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL fetch_hit_stall got=%b exp=0", mem_stall); end
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL fetch_hit_req got=%b exp=0", bus.mem_req); end
    @(negedge clk_from_ip);
    #1;
    checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL fetch_hit2_stall got=%b exp=0", mem_stall); end
  endtask
  task automatic test_write;
    int st;
    logic [31:0] q, fwd;
    logic [29:0] fa;
    logic fwe;
    logic [3:0] fm;
    lat = 4;
    do_op(1'b0, 1'b1, 30'h1000, 32'h01, 4'hF, st, q, fa, fwe, fwd, fm);
    checks++; if (st !== 5) begin failures++; $display("FAIL write_stall_cycles got=%0d exp=5", st); end
    checks++; if (fwe !== 1'b1) begin failures++; $display("FAIL write_mem_we got=%b exp=1", fwe); end
    checks++; if (fa !== 30'h1000) begin failures++; $display("FAIL write_mem_addr got=%h exp=1000", fa); end
    checks++; if (fwd !== 32'h01) begin failures++; $display("FAIL write_mem_wdata got=%h exp=1", fwd); end
    checks++; if (fm !== 4'hF) begin failures++; $display("FAIL write_mem_wmask got=%h exp=f", fm); end
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL write_req_dropped got=%b exp=0", bus.mem_req); end
    checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL write_after_stall got=%b exp=0", mem_stall); end
  endtask
  task automatic test_read_back;
    int st;
    logic [31:0] q, fwd;
    logic [29:0] fa;
    logic fwe;
    logic [3:0] fm;
    lat = 2;
    do_op(1'b1, 1'b0, 30'h1000, 32'h0, 4'h0, st, q, fa, fwe, fwd, fm);
    checks++; if (st !== 3) begin failures++; $display("FAIL read_stall_cycles got=%0d exp=3", st); end
    checks++; if (q !== 32'h01) begin failures++; $display("FAIL read_data_at_stall_fall got=%h exp=1", q); end
    checks++; if (fwe !== 1'b0 || fa !== 30'h1000) begin failures++; $display("FAIL read_bus_req got we=%b addr=%h exp we=0 addr=1000", fwe, fa); end
    #1;
    checks++; if (dmem_data_out !== 32'h01) begin failures++; $display("FAIL read_data_held got=%h exp=1", dmem_data_out); end
  endtask
  task automatic test_walking;
    int st;
    logic [31:0] q, fwd;
    logic [29:0] fa;
    logic fwe;
    logic [3:0] fm;
    lat = 1;
    for (int k = 0; k < 8; k++) begin
      do_op(1'b0, 1'b1, 30'h2000 + 30'(33 * k), 32'h1 << k, 4'hF, st, q, fa, fwe, fwd, fm);
      checks++; if (st !== 2) begin failures++; $display("FAIL walk_write%0d_stalls got=%0d exp=2", k, st); end
    end
    for (int k = 0; k < 8; k++) begin
      do_op(1'b1, 1'b0, 30'h2000 + 30'(33 * k), 32'h0, 4'h0, st, q, fa, fwe, fwd, fm);
      checks++; if (q !== (32'h1 << k)) begin failures++; $display("FAIL walk_read%0d got=%h exp=%h", k, q, 32'h1 << k); end
    end
  endtask
  task automatic test_both_high;
    int n0;
    n0 = log_addr.size();
    @(negedge clk_from_ip);
    dmem_read_in = 1'b1;
    dmem_write_in = 1'b1;
    dmem_addr = 30'h1000;
    data_from_reg = 32'hFFFF_FFFF;
    dc_byte_w_en = 4'hF;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.mem_req !== 1'b0) begin failures++; $display("FAIL both_high_req%0d got=%b exp=0", c, bus.mem_req); end
      checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL both_high_stall%0d got=%b exp=0", c, mem_stall); end
      @(negedge clk_from_ip);
    end
    dmem_read_in = 1'b0;
    dmem_write_in = 1'b0;
    checks++; if (log_addr.size() !== n0) begin failures++; $display("FAIL both_high_accesses got=%0d exp=%0d", log_addr.size(), n0); end
  endtask
  task automatic test_priority;
    int n, n0;
    lat = 1;
    @(negedge clk_from_ip);
    rst = 1'b1;
    ic_addr = 30'h0;
    dmem_addr = 30'h1000;
    dmem_read_in = 1'b1;
    repeat (2) @(negedge clk_from_ip);
    rst = 1'b0;
    n0 = log_addr.size();
    n = 0;
    #1;
    while (!bus.mem_ack && n < 50) begin
      n++;
      @(negedge clk_from_ip);
      #1;
    end
    checks++; if (n >= 50) begin failures++; $display("FAIL prio_data_ack got=timeout exp=ack"); end
    checks++; if (log_addr.size() !== n0 + 1 || log_addr[n0] !== 30'h1000 || log_we[n0] !== 1'b0)
      begin failures++; $display("FAIL prio_first_access got size=%0d exp first=read 1000", log_addr.size() - n0); end
    checks++; if (dmem_data_out !== 32'h01) begin failures++; $display("FAIL prio_load_data got=%h exp=1", dmem_data_out); end
    checks++; if (mem_stall !== 1'b1) begin failures++; $display("FAIL prio_fetch_still_stalls got=%b exp=1", mem_stall); end
    @(negedge clk_from_ip);
    dmem_read_in = 1'b0;
    n = 0;
    #1;
    while (mem_stall && n < 50) begin
      n++;
      @(negedge clk_from_ip);
      #1;
    end
    checks++; if (log_addr.size() !== n0 + 2 || log_addr[n0 + 1] !== 30'h0 || log_we[n0 + 1] !== 1'b0)
      begin failures++; $display("FAIL prio_second_access got size=%0d exp second=fetch 0", log_addr.size() - n0); end
    @(negedge clk_from_ip);
    #1;
    checks++; if (ic_data_out !== 32'hDEADBEEF) begin failures++; $display("FAIL prio_ic_data got=%h exp=deadbeef", ic_data_out); end
    checks++; if (mem_stall !== 1'b0) begin failures++; $display("FAIL prio_hit_stall got=%b exp=0", mem_stall); end
  endtask
  task automatic test_store_invalidate;
    int st, n;
    logic [31:0] q, fwd;
    logic [29:0] fa;
    logic fwe;
    logic [3:0] fm;
    lat = 1;
    do_op(1'b0, 1'b1, 30'h0, 32'h1234_5678, 4'hF, st, q, fa, fwe, fwd, fm);
    checks++; if (st !== 2) begin failures++; $display("FAIL inval_write_stalls got=%0d exp=2", st); end
    #1;
    checks++; if (mem_stall !== 1'b1) begin failures++; $display("FAIL inval_refetch_stall got=%b exp=1", mem_stall); end
    n = 0;
    while (mem_stall && n < 50) begin
      n++;
      @(negedge clk_from_ip);
      #1;
    end
    @(negedge clk_from_ip);
    #1;
    checks++; if (ic_data_out !== 32'h1234_5678) begin failures++; $display("FAIL inval_ic_data got=%h exp=12345678", ic_data_out); end
  endtask
  initial begin
    mem_arr[30'h0] = 32'hDEADBEEF;
    test_reset;
    test_fetch;
    test_write;
    test_read_back;
    test_walking;
    test_both_high;
    test_priority;
    test_store_invalidate;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
